// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : ALU control encoding and default datapath width                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter_if : two requester channels and one response channel         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_ctl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_ctl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  // Requesters and response consumer
  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready
  );

endinterface : alu_arbiter_if

`default_nettype wire

// File: rtl/alu_core.sv
// +--------------------------------------------------------------------------+
// | alu_core : combinational add/and/or/sub with zero flag                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  // Carry/borrow is intentionally dropped: results wrap modulo 2^WIDTH.
  always_comb begin
    result_o = '0;
    case (ctl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SUB: result_o = a_i - b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule : alu_core

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter : round-robin share of one ALU, registered response slot     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_id_q,     rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q,   rsp_zero_d;
  logic             last_q,       last_d;

  logic             can_accept;
  logic             grant;
  logic             any_valid;
  logic             xfer;
  logic [1:0]       sel_ctl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign any_valid  = bus.req0_valid || bus.req1_valid;

  // Contested cycle goes to whoever was not granted last time.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = can_accept && (grant == 1'b0);
  assign bus.req1_ready = can_accept && (grant == 1'b1);
  assign xfer           = can_accept && any_valid;

  assign sel_ctl = grant ? bus.req1_ctl : bus.req0_ctl;
  assign sel_a   = grant ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b   : bus.req0_b;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .ctl_i    (sel_ctl),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    last_d       = last_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      last_d       = grant;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // last resets to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      last_q       <= last_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule : alu_arbiter

`default_nettype wire
